vga_block_scan: RTL and testbench
=================================

VGA_BLOCK_SCAN -- requirements
Module: vga_block_scan

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- H_VIS 640, visible pixels per line
- H_FP 16, H_SYNC 96, H_BP 48 (line total 800)
- V_VIS 480, visible lines
- V_FP 10, V_SYNC 2, V_BP 33 (frame total 525)
- BOARD_X0 220, board left pixel
- BOARD_Y0 40, board top line
- BOARD_COLS 10, BOARD_ROWS 20
- block side: `BLOCK_SIDE from global.v (20)
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, 100 MHz system clock
- rst, in, 1, asynchronous active-high reset
- pclk_en, out, 1, one-cycle pixel tick, every 4th clk
- h_cnt, out, 10, pixel column 0..799
- v_cnt, out, 10, line 0..524
- hsync, out, 1, horizontal sync, active low
- vsync, out, 1, vertical sync, active low
- valid, out, 1, high inside the 640x480 visible area
- in_board, out, 1, high inside the board rectangle
- blk_col, out, 4, board column index 0..9
- blk_row, out, 5, board row index 0..19
- frame_start, out, 1, one-clk pulse when the scan wraps to (0,0)
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-high on rst.

Function
REQ-004 A 2-bit divider SHALL count every clk; pclk_en SHALL be 1 on the clk in which the divider value is 3.
REQ-005 All counters and outputs SHALL update only on clk edges where pclk_en is 1, except the divider and pclk_en.
REQ-006 h_cnt SHALL increment per tick and wrap 799->0; on that wrap v_cnt SHALL increment and wrap 524->0.
REQ-007 The following outputs SHALL be registered and consistent with the h_cnt/v_cnt values they accompany:
- hsync = 0 iff 656 <= h_cnt <= 751
- vsync = 0 iff 490 <= v_cnt <= 491
- valid = (h_cnt < 640) && (v_cnt < 480)
REQ-008 in_board SHALL be 1 iff both hold: 220 <= h_cnt <= 419 and 40 <= v_cnt <= 439.
REQ-009 blk_col SHALL equal floor((h_cnt-220)/20) and blk_row SHALL equal floor((v_cnt-40)/20) when in_board=1; both SHALL be 0 when in_board=0.
REQ-010 blk_col/blk_row SHALL be produced by incremental sub-block counters (5-bit, 0..19) rather than a divider or comparator ladder.
- Boundary pixel 240 (or line 60) SHALL map to index 1, not 0.
REQ-011 The column sub-counter SHALL restart at the first board pixel of every line; the row sub-counter SHALL advance only on line wrap and restart at line 40.
REQ-012 frame_start SHALL pulse for exactly one clk on the tick where (h_cnt,v_cnt) becomes (0,0), and SHALL be 0 otherwise.
REQ-013 No output SHALL exceed its stated range.
- blk_col never reaches 10; blk_row never reaches 20.

Reset
REQ-014 While rst=1, the following SHALL hold, asynchronously and independent of clk:
- divider=0, pclk_en=0
- h_cnt=0, v_cnt=0
- hsync=1, vsync=1, valid=1
- in_board=0, blk_col=0, blk_row=0
- frame_start=0, sub-counters=0
REQ-015 After rst is released mid-frame, the first pclk_en SHALL occur on the 4th clk edge, and scanning SHALL restart from (0,0) with no partial-line artefacts.

Verification
REQ-016 Release reset, run 3,360,000 clk (two frames):
- pclk_en period is 4 clk
- frame_start pulses exactly twice, 1,680,000 clk apart
- every line is 800 ticks; every frame is 525 lines
REQ-017 Sync window check:
- hsync low exactly for h_cnt 656..751 (96 ticks)
- vsync low exactly for v_cnt 490..491
- valid=0 at h_cnt=640 and at v_cnt=480
REQ-018 Board mapping check:
- (h,v)=(219,40) -> in_board=0, blk_col=0
- (220,40) -> in_board=1, col=0, row=0
- (239,59) -> col=0, row=0
- (240,60) -> col=1, row=1
- (419,439) -> col=9, row=19
- (420,439) -> in_board=0
REQ-019 Exhaustive compare over one frame: blk_col, blk_row and in_board match the REQ-008/009 formula for all 420,000 positions.
REQ-020 Reset mid-frame:
- Assert rst at (h,v)=(300,200) -> all REQ-014 values at once, before the next clk edge.
- Deassert rst -> h_cnt=1 after 4 clk; vsync/hsync stay 1 until their windows.

Source files
------------

// File: rtl/vga_block_scan.sv
// VGA raster scanner with pixel-tick divider and board block-index tracking.
// Block indices come from incremental sub-block counters, not division.
module vga_block_scan #(
    parameter int H_VIS      = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VIS      = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int BOARD_X0   = 220,
    parameter int BOARD_Y0   = 40,
    parameter int BOARD_COLS = 10,
    parameter int BOARD_ROWS = 20,
    parameter int BLOCK_SIDE = 20
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pclk_en,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       hsync,
    output logic       vsync,
    output logic       valid,
    output logic       in_board,
    output logic [3:0] blk_col,
    output logic [4:0] blk_row,
    output logic       frame_start
);

    localparam logic [9:0] H_LAST = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HS_BEG = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END = 10'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic [9:0] HV     = 10'(H_VIS);
    localparam logic [9:0] VV     = 10'(V_VIS);
    localparam logic [9:0] BX0    = 10'(BOARD_X0);
    localparam logic [9:0] BX1    = 10'(BOARD_X0 + BOARD_COLS * BLOCK_SIDE - 1);
    localparam logic [9:0] BY0    = 10'(BOARD_Y0);
    localparam logic [9:0] BY1    = 10'(BOARD_Y0 + BOARD_ROWS * BLOCK_SIDE - 1);
    localparam logic [4:0] SUB_LAST = 5'(BLOCK_SIDE - 1);

    logic [1:0] div;
    logic [4:0] sub_x, sub_y, sx_nx, sy_nx;
    logic [3:0] cx, cx_nx;
    logic [4:0] ry, ry_nx;
    logic [9:0] h_nx, v_nx;
    logic       line_wrap, hx_in, vy_in, inb_nx;

    // Everything below is computed for the position the next tick moves to,
    // so the registered outputs always match the counters they travel with.
    always_comb begin
        line_wrap = (h_cnt == H_LAST);
        h_nx      = line_wrap ? 10'd0 : h_cnt + 10'd1;
        v_nx      = v_cnt;
        if (line_wrap)
            v_nx = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;

        hx_in  = (h_nx >= BX0) && (h_nx <= BX1);
        vy_in  = (v_nx >= BY0) && (v_nx <= BY1);
        inb_nx = hx_in && vy_in;

        sx_nx = 5'd0;
        cx_nx = 4'd0;
        if (hx_in && (h_nx != BX0)) begin
            if (sub_x == SUB_LAST) begin
                cx_nx = cx + 4'd1;
            end else begin
                sx_nx = sub_x + 5'd1;
                cx_nx = cx;
            end
        end

        sy_nx = sub_y;
        ry_nx = ry;
        if (line_wrap) begin
            sy_nx = 5'd0;
            ry_nx = 5'd0;
            if (vy_in && (v_nx != BY0)) begin
                if (sub_y == SUB_LAST) begin
                    ry_nx = ry + 5'd1;
                end else begin
                    sy_nx = sub_y + 5'd1;
                    ry_nx = ry;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div         <= 2'd0;
            pclk_en     <= 1'b0;
            h_cnt       <= 10'd0;
            v_cnt       <= 10'd0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            valid       <= 1'b1;
            in_board    <= 1'b0;
            blk_col     <= 4'd0;
            blk_row     <= 5'd0;
            frame_start <= 1'b0;
            sub_x       <= 5'd0;
            sub_y       <= 5'd0;
            cx          <= 4'd0;
            ry          <= 5'd0;
        end else begin
            div         <= div + 2'd1;
            pclk_en     <= (div == 2'd2);
            frame_start <= 1'b0;
            if (pclk_en) begin
                h_cnt       <= h_nx;
                v_cnt       <= v_nx;
                hsync       <= !((h_nx >= HS_BEG) && (h_nx <= HS_END));
                vsync       <= !((v_nx >= VS_BEG) && (v_nx <= VS_END));
                valid       <= (h_nx < HV) && (v_nx < VV);
                in_board    <= inb_nx;
                blk_col     <= inb_nx ? cx_nx : 4'd0;
                blk_row     <= inb_nx ? ry_nx : 5'd0;
                frame_start <= (h_nx == 10'd0) && (v_nx == 10'd0);
                sub_x       <= sx_nx;
                sub_y       <= sy_nx;
                cx          <= cx_nx;
                ry          <= ry_nx;
            end
        end
    end

endmodule

// File: tb/tb_vga_block_scan.sv
// Bench for vga_block_scan on a reduced raster so whole frames fit a short run.
module tb_vga_block_scan;

    localparam int HV = 64, HF = 4, HS = 8, HB = 4;
    localparam int VV = 30, VF = 2, VS = 2, VB = 4;
    localparam int X0 = 12, Y0 = 3, C = 10, R = 6, S = 4;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int F  = 4 * HT * VT;

    logic       clk;
    logic       rst;
    logic       pclk_en;
    logic [9:0] h_cnt, v_cnt;
    logic       hsync, vsync, valid, in_board, frame_start;
    logic [3:0] blk_col;
    logic [4:0] blk_row;

    vga_block_scan #(
        .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .BOARD_X0(X0), .BOARD_Y0(Y0), .BOARD_COLS(C), .BOARD_ROWS(R),
        .BLOCK_SIDE(S)
    ) dut (
        .clk(clk), .rst(rst), .pclk_en(pclk_en),
        .h_cnt(h_cnt), .v_cnt(v_cnt),
        .hsync(hsync), .vsync(vsync), .valid(valid),
        .in_board(in_board), .blk_col(blk_col), .blk_row(blk_row),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int k = 0;
    bit mon_en = 1'b0;
    int fs_k[$];

    localparam logic [34:0] RST_VEC =
        {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 5'd0, 1'b0};

    always @(posedge clk or posedge rst)
        if (rst) k <= 0;
        else     k <= k + 1;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [34:0] observed();
        return {pclk_en, h_cnt, v_cnt, hsync, vsync, valid,
                in_board, blk_col, blk_row, frame_start};
    endfunction

    // Expected outputs after kk clock edges since reset release
    function automatic logic [34:0] model(int kk);
        int t, h, v, col, row;
        logic pc, fs, hs, vs, val, inb;
        t   = kk / 4;
        h   = t % HT;
        v   = (t / HT) % VT;
        pc  = (kk % 4 == 3);
        fs  = (kk > 0) && (kk % 4 == 0) && (t % (HT * VT) == 0);
        hs  = !(h >= HV + HF && h < HV + HF + HS);
        vs  = !(v >= VV + VF && v < VV + VF + VS);
        val = (h < HV) && (v < VV);
        inb = (h >= X0) && (h < X0 + C * S) && (v >= Y0) && (v < Y0 + R * S);
        col = inb ? (h - X0) / S : 0;
        row = inb ? (v - Y0) / S : 0;
        return {pc, 10'(h), 10'(v), hs, vs, val, inb, 4'(col), 5'(row), fs};
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            chk("scan", 64'(observed()), 64'(model(k)));
            if (frame_start) fs_k.push_back(k);
        end
    end

    typedef struct {
        int   h;
        int   v;
        logic inb;
        int   col;
        int   row;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int n;
        tbl[0] = '{X0 - 1,         Y0,             1'b0, 0,     0};
        tbl[1] = '{X0,             Y0,             1'b1, 0,     0};
        tbl[2] = '{X0 + S - 1,     Y0 + S - 1,     1'b1, 0,     0};
        tbl[3] = '{X0 + S,         Y0 + S,         1'b1, 1,     1};
        tbl[4] = '{X0 + C * S - 1, Y0 + R * S - 1, 1'b1, C - 1, R - 1};
        tbl[5] = '{X0 + C * S,     Y0 + R * S - 1, 1'b0, 0,     0};

        rst = 1'b0;
        #1 rst = 1'b1;
        mon_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_state", 64'(observed()), 64'(RST_VEC));
        fs_k.delete();
        rst = 1'b0;

        repeat (2 * F + 20) @(negedge clk);
        chk("fs_count", 64'(fs_k.size()), 64'd2);
        if (fs_k.size() == 2) begin
            chk("fs_first", 64'(fs_k[0]), 64'(F));
            chk("fs_spacing", 64'(fs_k[1] - fs_k[0]), 64'(F));
        end

        for (int i = 0; i < 6; i++) begin
            n = 0;
            while (!(h_cnt == 10'(tbl[i].h) && v_cnt == 10'(tbl[i].v)) && n < F) begin
                @(negedge clk);
                n++;
            end
            if (n >= F) begin
                chk($sformatf("tbl%0d_timeout", i), 64'd0, 64'd1);
            end else begin
                chk($sformatf("tbl%0d_inb", i), 64'(in_board), 64'(tbl[i].inb));
                chk($sformatf("tbl%0d_col", i), 64'(blk_col), 64'(tbl[i].col));
                chk($sformatf("tbl%0d_row", i), 64'(blk_row), 64'(tbl[i].row));
            end
        end

        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(50, 3000)) @(negedge clk);
            #($urandom_range(1, 3));
            rst = 1'b1;
            #1 chk($sformatf("async_rst%0d", r), 64'(observed()), 64'(RST_VEC));
            repeat ($urandom_range(1, 5)) @(negedge clk);
            rst = 1'b0;
        end

        n = 0;
        while (!(h_cnt == 10'd30 && v_cnt == 10'd20) && n < F) begin
            @(negedge clk);
            n++;
        end
        if (n >= F) chk("mid_wait_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("mid_rst", 64'(observed()), 64'(RST_VEC));
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("h_after3", 64'(h_cnt), 64'd0);
        @(posedge clk);
        #1 chk("h_after4", 64'(h_cnt), 64'd1);
        chk("sync_after4", 64'({hsync, vsync}), 64'd3);
        repeat (400) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
